// File: rtl/sub_div_if.sv
// sub_div_if: start/done handshake, sub_op operand/result bus and divide results.
interface sub_div_if #(
    parameter int WA = 4,
    parameter int WB = 2
);
    logic          start;
    logic [WA-1:0] a_in;
    logic [WB-1:0] b_in;
    logic [WA-1:0] sub_a;
    logic [WB-1:0] sub_b;
    logic [WA-1:0] sub_y;
    logic          sub_c;
    logic          busy;
    logic          done;
    logic [WA-1:0] quotient;
    logic [WA-1:0] remainder;
    logic          div_zero;
    modport slave (
        input  start, a_in, b_in, sub_y, sub_c,
        output sub_a, sub_b, busy, done, quotient, remainder, div_zero
    );
    modport master (
        output start, a_in, b_in, sub_y, sub_c,
        input  sub_a, sub_b, busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/sub_div_ctrl.sv
// sub_div_ctrl: unsigned A/B by repeated subtraction on a shared external subtractor.
module sub_div_ctrl #(
    parameter int WA = 4,
    parameter int WB = 2
) (
    input  logic        clk,
    input  logic        rst,
    sub_div_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
    state_t        state, state_d;
    logic [WA-1:0] rem_r, quo_r, quotient, remainder;
    logic [WB-1:0] div_r;
    logic          div_zero;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end
    always_comb begin
        state_d = state;
        if (state == IDLE && bus.start) state_d = (bus.b_in == '0) ? DONE : SUB;
        else if (state == SUB && !bus.sub_c) state_d = DONE;
        else if (state == DONE) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r     <= '0;
            div_r     <= '0;
            quo_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            rem_r    <= bus.a_in;
            div_r    <= bus.b_in;
            quo_r    <= '0;
            div_zero <= (bus.b_in == '0);
            if (bus.b_in == '0) begin
                quotient  <= '1;
                remainder <= bus.a_in;
            end
        end else if (state == SUB) begin
            if (bus.sub_c) begin
                rem_r <= bus.sub_y;
                quo_r <= quo_r + 1'b1;
            end else begin
                quotient  <= quo_r;
                remainder <= rem_r;
            end
        end
    end
    assign bus.sub_a     = (state == SUB) ? rem_r : '0;
    assign bus.sub_b     = (state == SUB) ? div_r : '0;
    assign bus.busy      = (state == SUB);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.div_zero  = div_zero;
endmodule
